// File: rtl/pulse_count_receiver.sv
// Slow-domain receiver of the fast-to-slow pulse-count handshake: captures a count
// from the sender and replays it as evenly spaced single-cycle pulses.
module pulse_count_receiver #(
   parameter int WIDTH       = 32,
   parameter int SYNC_STAGES = 2,
   parameter int PULSE_GAP   = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             valid,
   input  logic [WIDTH-1:0] count,
   output logic             ready,
   output logic             ack,
   output logic             pulse,
   output logic             busy,
   output logic [WIDTH-1:0] pending
);

   localparam int GAP_W = $clog2(PULSE_GAP + 1);

   typedef enum logic [3:0] {
      START = 4'b0001,
      IDLE  = 4'b0010,
      ACK   = 4'b0100,
      DRAIN = 4'b1000
   } state_t;

   state_t                 state_reg, state_next;
   logic [SYNC_STAGES-1:0] sync_reg;
   logic                   valid_s;
   logic [WIDTH-1:0]       remaining_reg, remaining_next;
   logic [GAP_W-1:0]       gap_reg, gap_next;
   logic                   pulse_reg, pulse_next;

   assign valid_s = sync_reg[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_reg      <= '0;
         state_reg     <= START;
         remaining_reg <= '0;
         gap_reg       <= '0;
         pulse_reg     <= 1'b0;
      end else begin
         sync_reg      <= {sync_reg[SYNC_STAGES-2:0], valid};
         state_reg     <= state_next;
         remaining_reg <= remaining_next;
         gap_reg       <= gap_next;
         pulse_reg     <= pulse_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      remaining_next = remaining_reg;
      gap_next       = gap_reg;
      pulse_next     = 1'b0;

      // Emitter runs regardless of state; gap is never cleared so spacing
      // carries over into the next transaction.
      if (remaining_reg != '0 && gap_reg == '0) begin
         pulse_next     = 1'b1;
         remaining_next = remaining_reg - WIDTH'(1);
         gap_next       = GAP_W'(PULSE_GAP - 1);
      end else if (gap_reg != '0) begin
         gap_next = gap_reg - GAP_W'(1);
      end

      case (state_reg)
         START: state_next = IDLE;
         IDLE: begin
            // remaining is always zero here, so capture never collides with a decrement
            if (valid_s) begin
               remaining_next = count;
               state_next     = ACK;
            end
         end
         ACK: begin
            if (!valid_s)
               state_next = (remaining_reg != '0) ? DRAIN : IDLE;
         end
         DRAIN: begin
            if (remaining_reg == '0)
               state_next = IDLE;
         end
         default: state_next = START;
      endcase
   end

   assign ready   = state_reg[1];
   assign ack     = state_reg[2];
   assign busy    = ~state_reg[1];
   assign pulse   = pulse_reg;
   assign pending = remaining_reg;

endmodule

// File: tb/tb_pulse_count_receiver.sv
// Bench for pulse_count_receiver: directed and randomized transfers checked every
// cycle against a transaction-level timing model of the handshake and pulse train.
module tb_pulse_count_receiver;

   localparam int WIDTH = 6;
   localparam int SYNC  = 2;
   localparam int GAP   = 2;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             valid = 1'b0;
   logic [WIDTH-1:0] count = '0;
   logic             ready, ack, pulse, busy;
   logic [WIDTH-1:0] pending;

   pulse_count_receiver #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC), .PULSE_GAP(GAP)) dut (
      .clk(clk), .rst_n(rst_n), .valid(valid), .count(count),
      .ready(ready), .ack(ack), .pulse(pulse), .busy(busy), .pending(pending)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Model: cycle index of the latest edge (0 = edge at which reset was released)
   // and busy/ack windows of the current and previous transaction.
   int cyc;
   int cap_e, rdy_e, ackf_e, pcap_e, prdy_e, packf_e;
   int last_pulse;
   int pq_t[$];
   int pq_cap[$];
   int seen_pulses, last_seen, exp_pulses;

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   function automatic bit in_win(input int c, input int a, input int b);
      return (c >= a) && (c < b);
   endfunction

   function automatic int pend_model(input int c);
      int n = 0;
      foreach (pq_t[i]) if (pq_t[i] > c && pq_cap[i] <= c) n++;
      return n;
   endfunction

   function automatic bit pulse_model(input int c);
      foreach (pq_t[i]) if (pq_t[i] == c) return 1'b1;
      return 1'b0;
   endfunction

   task automatic reset_model();
      pq_t.delete();
      pq_cap.delete();
      cyc = 0;
      cap_e = 0; rdy_e = 1; ackf_e = 0;
      pcap_e = 0; prdy_e = 0; packf_e = 0;
      last_pulse = -1000;
      last_seen = -1000;
   endtask

   task automatic check_cycle();
      bit ready_exp, ack_exp;
      ready_exp = !in_win(cyc, cap_e, rdy_e) && !in_win(cyc, pcap_e, prdy_e);
      ack_exp   = in_win(cyc, cap_e, ackf_e) || in_win(cyc, pcap_e, packf_e);
      chk("ready", ready, ready_exp);
      chk("ack", ack, ack_exp);
      chk("busy", busy, !ready_exp);
      chk("pulse", pulse, pulse_model(cyc));
      chk("pending", pending, pend_model(cyc));
      if (pulse === 1'b1) begin
         seen_pulses++;
         if (last_seen > -1000) chk("pulse_spacing_ok", (cyc - last_seen) >= GAP, 1);
         last_seen = cyc;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      #1;
      check_cycle();
   endtask

   task automatic wait_idle();
      while (cyc < rdy_e) tick();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_ready", ready, 0);
      chk("rst_ack", ack, 0);
      chk("rst_pulse", pulse, 0);
      chk("rst_busy", busy, 1);
      chk("rst_pending", pending, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      reset_model();
      check_cycle();
   endtask

   // Sender: raise valid now, hold it until 'hold' cycles past the capture edge.
   task automatic xfer(input int n, input int hold);
      int cap, ackf, first, last, rdy;
      while (cyc < ackf_e) tick();
      cap   = max2(cyc + SYNC + 1, rdy_e + 1);
      ackf  = cap + hold + SYNC + 1;
      first = max2(cap + 1, last_pulse + GAP);
      last  = first + (n - 1) * GAP;
      for (int k = 0; k < n; k++) begin
         pq_t.push_back(first + k * GAP);
         pq_cap.push_back(cap);
      end
      if (n > 0) last_pulse = last;
      rdy = (n > 0) ? max2(ackf, last + 1) : ackf;
      pcap_e = cap_e; prdy_e = rdy_e; packf_e = ackf_e;
      cap_e = cap; rdy_e = rdy; ackf_e = ackf;
      exp_pulses += n;
      $display("txn count=%0d hold=%0d launch=%0d capture=%0d ack_fall=%0d ready=%0d",
               n, hold, cyc, cap, ackf, rdy);
      count = WIDTH'(n);
      valid = 1'b1;
      while (cyc < cap + hold) tick();
      valid = 1'b0;
      count = WIDTH'($urandom);
   endtask

   initial begin
      int base, n, dropped;
      seen_pulses = 0;
      exp_pulses  = 0;
      reset_model();
      #2;
      do_reset();
      repeat (2) tick();

      base = seen_pulses;
      xfer(5, 0);
      wait_idle();
      chk("pulses_count5", seen_pulses - base, 5);

      base = seen_pulses;
      xfer(0, 1);
      wait_idle();
      chk("pulses_count0", seen_pulses - base, 0);

      // New valid raised mid-DRAIN must wait for IDLE.
      base = seen_pulses;
      xfer(40, 0);
      repeat (10) tick();
      n = $urandom_range(1, 5);
      xfer(n, 0);
      wait_idle();
      chk("pulses_drain", seen_pulses - base, 40 + n);

      base = seen_pulses;
      xfer(3, 0);
      wait_idle();
      xfer(2, 0);
      wait_idle();
      chk("pulses_b2b", seen_pulses - base, 5);

      for (int t = 0; t < 8; t++) begin
         if ($urandom_range(0, 1) == 1) wait_idle();
         repeat ($urandom_range(0, 4)) tick();
         xfer($urandom_range(0, 12), $urandom_range(0, 3));
      end
      wait_idle();

      base = seen_pulses;
      xfer(63, 0);
      wait_idle();
      chk("pulses_max", seen_pulses - base, 63);

      xfer(30, 0);
      while (pend_model(cyc) > 17) tick();
      chk("pending_before_reset", pending, 17);
      dropped = pend_model(cyc);
      exp_pulses -= dropped;
      do_reset();
      tick();
      base = seen_pulses;
      xfer(4, 0);
      wait_idle();
      repeat (3) tick();
      chk("pulses_after_reset", seen_pulses - base, 4);
      chk("pulses_total", seen_pulses, exp_pulses);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
